// File: rtl/sens_pxd_framer.sv
// Frames the mclk-registered sensor pixel bus into a marked pixel stream with counters and sticky errors.
// Defining SENS_PXD_LINE_LEN_CHECK_EN builds the per-frame line-length check (line_len / err_line_len).
module sens_pxd_framer #(
  parameter int PXD_WIDTH = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic [PXD_WIDTH-1:0] pxd,
  input  logic                 hact,
  input  logic                 vact,
  input  logic                 frame_en,
  input  logic [CNT_WIDTH-1:0] lines_max,
  input  logic                 err_clr,
  output logic [PXD_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic [CNT_WIDTH-1:0] line_num,
  output logic [CNT_WIDTH-1:0] pix_num,
  output logic [CNT_WIDTH-1:0] line_len,
  output logic                 err_hact_out,
  output logic                 err_line_len
);

  typedef enum logic [1:0] {ST_SYNC, ST_WAIT, ST_FRAME} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nxt;

  logic [PXD_WIDTH-1:0] a_pxd;
  logic                 a_hact;
  logic                 a_vact;
  logic                 a_fen;
  logic                 a_clr;
  logic                 a_hact_d;
  logic                 a_vact_d;

  logic [CNT_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] cur_line;
  logic [CNT_WIDTH-1:0] cur_pix;
  logic                 sof_seen;
  logic                 seen;
  logic                 start;
  logic                 in_frame;
  logic                 line_start;
  logic                 supp;
  logic                 pix_ok;
  logic                 last_pix;
  logic                 eol_c;
  logic                 eof_c;
  logic                 err_set;

  // Stage A. vact history resets high so SYNC only leaves on a genuinely sampled low.
  always_ff @(posedge mclk) begin
    if (rst) begin
      a_pxd    <= '0;
      a_hact   <= 1'b0;
      a_vact   <= 1'b1;
      a_fen    <= 1'b0;
      a_clr    <= 1'b0;
      a_hact_d <= 1'b0;
      a_vact_d <= 1'b1;
    end else begin
      a_pxd    <= pxd;
      a_hact   <= hact;
      a_vact   <= vact;
      a_fen    <= frame_en;
      a_clr    <= err_clr;
      a_hact_d <= a_hact;
      a_vact_d <= a_vact;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nxt;
  end

  // The live input acts as a one-sample lookahead on stage A, so eol lands on the last pixel.
  always_comb begin
    start      = (state == ST_WAIT) && a_vact && !a_vact_d && a_fen;
    in_frame   = start || ((state == ST_FRAME) && a_vact);
    line_start = a_hact && (!a_hact_d || start);
    cur_line   = start ? '0 : line_cnt;
    cur_pix    = line_start ? '0 : pix_num + CNT_ONE;
    supp       = (lines_max != '0) && (cur_line >= lines_max);
    pix_ok     = in_frame && a_hact && !supp;
    last_pix   = !hact || !vact;
    eol_c      = pix_ok && last_pix;
    eof_c      = (state == ST_FRAME) && !a_vact;
    seen       = start ? 1'b0 : sof_seen;
    err_set    = (state == ST_WAIT) && a_hact && !start;
    state_nxt  = state;
    case (state)
      ST_SYNC:  if (!a_vact) state_nxt = ST_WAIT;
      ST_WAIT:  if (start) state_nxt = ST_FRAME;
      ST_FRAME: if (!a_vact) state_nxt = ST_WAIT;
      default:  state_nxt = ST_SYNC;
    endcase
  end

  // Stage B.
  always_ff @(posedge mclk) begin
    if (rst) begin
      dout         <= '0;
      dout_valid   <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      line_num     <= '0;
      pix_num      <= '0;
      line_cnt     <= '0;
      sof_seen     <= 1'b0;
      err_hact_out <= 1'b0;
    end else begin
      dout_valid   <= pix_ok;
      sof          <= pix_ok && !seen;
      eol          <= eol_c;
      eof          <= eof_c;
      sof_seen     <= seen || pix_ok;
      err_hact_out <= err_set || (err_hact_out && !a_clr);
      if (pix_ok) begin
        dout     <= a_pxd;
        line_num <= cur_line;
        pix_num  <= cur_pix;
      end
      if (eol_c && (cur_line != CNT_MAX)) line_cnt <= cur_line + CNT_ONE;
      else                                line_cnt <= cur_line;
    end
  end

`ifdef SENS_PXD_LINE_LEN_CHECK_EN
  logic                 len_locked;
  logic                 locked;
  logic                 full_line;
  logic [CNT_WIDTH-1:0] len_c;

  // A line ending on vact low is truncated and never becomes or checks the reference.
  always_comb begin
    full_line = eol_c && vact;
    len_c     = cur_pix + CNT_ONE;
    locked    = start ? 1'b0 : len_locked;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      len_locked   <= 1'b0;
      line_len     <= '0;
      err_line_len <= 1'b0;
    end else begin
      len_locked <= locked || full_line;
      if (full_line && !locked) line_len <= len_c;
      err_line_len <= (full_line && locked && (len_c != line_len)) || (err_line_len && !a_clr);
    end
  end
`else
  assign line_len     = '0;
  assign err_line_len = 1'b0;
`endif

endmodule

// File: tb/tb_sens_pxd_framer.sv
// Bench for sens_pxd_framer: frames built from line-length lists, expected pixels/eofs predicted per frame.
module tb_sens_pxd_framer;
  localparam int PW    = 12;
  localparam int CW    = 16;
  localparam int REC_W = 32 + CW + CW + PW + 2;

  logic          mclk = 1'b0;
  logic          rst;
  logic [PW-1:0] pxd;
  logic          hact;
  logic          vact;
  logic          frame_en;
  logic [CW-1:0] lines_max;
  logic          err_clr;
  logic [PW-1:0] dout;
  logic          dout_valid;
  logic          sof;
  logic          eol;
  logic          eof;
  logic [CW-1:0] line_num;
  logic [CW-1:0] pix_num;
  logic [CW-1:0] line_len;
  logic          err_hact_out;
  logic          err_line_len;

  sens_pxd_framer #(.PXD_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .mclk(mclk), .rst(rst), .pxd(pxd), .hact(hact), .vact(vact), .frame_en(frame_en),
    .lines_max(lines_max), .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid),
    .sof(sof), .eol(eol), .eof(eof), .line_num(line_num), .pix_num(pix_num),
    .line_len(line_len), .err_hact_out(err_hact_out), .err_line_len(err_line_len)
  );

  // Clock and reset-sampling block
  always #5 mclk = ~mclk;

  int   cyc = 0;
  logic rst_q;
  always @(posedge mclk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int checks = 0;
  int failures = 0;
  int in_cyc;
  int lens[8];
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];
  int eof_exp[$];
  int eof_obs[$];
  int stray = 0;
  int hold_err = 0;
  logic [PW-1:0] last_dout;

  // Monitor: records {cycle, line, pixel, data, sof, eol} of every valid output
  always @(negedge mclk) begin
    if (dout_valid) obs_q.push_back({32'(cyc), line_num, pix_num, dout, sof, eol});
    else if (!rst_q) begin
      if (sof || eol) stray <= stray + 1;
      if (dout !== last_dout) hold_err <= hold_err + 1;
    end
    if (eof) eof_obs.push_back(cyc);
    last_dout <= dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drv(input logic h, input logic v, input logic r, input logic [PW-1:0] d);
    @(negedge mclk);
    hact   = h;
    vact   = v;
    rst    = r;
    pxd    = d;
    in_cyc = cyc;
  endtask

  task automatic drain;
    repeat (4) drv(1'b0, 1'b0, 1'b0, PW'($urandom));
  endtask

  task automatic pulse_clr;
    drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    err_clr = 1'b1;
    drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    err_clr = 1'b0;
    drain();
  endtask

  // One frame of nl lines (lengths in lens[]); predicts outputs when acc is set.
  task automatic drive_frame(input int nl, input bit acc, input int lmax, input bit trunc,
                             input bit hv_same, input bit rst_gap, input bit ramp, input bit fen_drop);
    int gap;
    logic [PW-1:0] d;
    lines_max = CW'(lmax);
    repeat ($urandom_range(2, 4)) drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    for (int l = 0; l < nl; l++) begin
      if (l == 0) gap = hv_same ? 0 : (rst_gap ? 3 : int'($urandom_range(1, 3)));
      else gap = $urandom_range(1, 3);
      if (fen_drop && l == 1) frame_en = 1'b0;
      for (int g = 0; g < gap; g++) drv(1'b0, 1'b1, rst_gap && l == 0 && g == 1, PW'($urandom));
      for (int p = 0; p < lens[l]; p++) begin
        d = ramp ? PW'(l * 8 + p) : PW'($urandom);
        drv(1'b1, 1'b1, 1'b0, d);
        if (acc && (lmax == 0 || l < lmax))
          exp_q.push_back({32'(in_cyc + 2), CW'(l), CW'(p), d, (l == 0 && p == 0), (p == lens[l] - 1)});
      end
    end
    if (trunc) drv(1'b1, 1'b0, 1'b0, PW'($urandom));
    else begin
      repeat ($urandom_range(1, 2)) drv(1'b0, 1'b1, 1'b0, PW'($urandom));
      drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    end
    if (acc) eof_exp.push_back(in_cyc + 2);
    drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    if (fen_drop) frame_en = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) drv(1'b1, 1'b1, 1'b1, PW'($urandom));
    checks++;
    if ({dout, dout_valid, sof, eol, eof} !== '0) begin
      failures++;
      $display("FAIL reset_stream got=%h exp=0", {dout, dout_valid, sof, eol, eof});
    end
    checks++;
    if ({line_num, pix_num, line_len} !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%h exp=0", {line_num, pix_num, line_len});
    end
    checks++;
    if ({err_hact_out, err_line_len} !== 2'b00) begin
      failures++;
      $display("FAIL reset_errors got=%b exp=00", {err_hact_out, err_line_len});
    end
    repeat (4) drv(1'b0, 1'b0, 1'b0, PW'($urandom));
  endtask

  task automatic test_basic;
    int nsof, neol;
    nsof = 0;
    neol = 0;
    lens = '{8, 8, 8, 0, 0, 0, 0, 0};
    drive_frame(3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    foreach (obs_q[i]) begin
      nsof += int'(obs_q[i][1]);
      neol += int'(obs_q[i][0]);
    end
    checks++;
    if (obs_q.size() != 24) begin failures++; $display("FAIL basic_valid_count got=%0d exp=24", obs_q.size()); end
    checks++;
    if (nsof != 1) begin failures++; $display("FAIL basic_sof_count got=%0d exp=1", nsof); end
    checks++;
    if (neol != 3) begin failures++; $display("FAIL basic_eol_count got=%0d exp=3", neol); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL basic_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  task automatic test_reset_mid_frame;
    lens = '{6, 5, 0, 0, 0, 0, 0, 0};
    drive_frame(2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_frame(2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL rstmid_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  task automatic test_line_limit;
    lens = '{8, 8, 8, 8, 0, 0, 0, 0};
    drive_frame(4, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lines_max = '0;
    drain();
    checks++;
    if (obs_q.size() != 16) begin failures++; $display("FAIL limit_count got=%0d exp=16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL limit_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL limit_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  task automatic test_hact_err;
    pulse_clr();
    checks++;
    if (err_hact_out !== 1'b0) begin failures++; $display("FAIL hact_err_idle got=%b exp=0", err_hact_out); end
    repeat (3) drv(1'b1, 1'b0, 1'b0, PW'($urandom));
    drain();
    checks++;
    if (err_hact_out !== 1'b1) begin failures++; $display("FAIL hact_err_set got=%b exp=1", err_hact_out); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL hact_err_valid got=%0d exp=0", obs_q.size()); end
    pulse_clr();
    checks++;
    if (err_hact_out !== 1'b0) begin failures++; $display("FAIL hact_err_clear got=%b exp=0", err_hact_out); end
    drv(1'b1, 1'b0, 1'b0, PW'($urandom));
    err_clr = 1'b1;
    drv(1'b0, 1'b0, 1'b0, PW'($urandom));
    err_clr = 1'b0;
    drain();
    checks++;
    if (err_hact_out !== 1'b1) begin failures++; $display("FAIL hact_err_set_wins got=%b exp=1", err_hact_out); end
    pulse_clr();
    obs_q.delete();
  endtask

  task automatic test_frame_en;
    lens = '{4, 4, 5, 0, 0, 0, 0, 0};
    frame_en = 1'b0;
    drive_frame(2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_en = 1'b1;
    drive_frame(2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_frame(3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL fen_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL fen_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL fen_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
    pulse_clr();
  endtask

  task automatic test_truncate_empty;
    lens = '{5, 6, 0, 0, 0, 0, 0, 0};
    drive_frame(2, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_frame(0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL trunc_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL trunc_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL trunc_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  task automatic test_line_len;
    logic [CW-1:0] exp_len;
    logic          exp_err;
`ifdef SENS_PXD_LINE_LEN_CHECK_EN
    exp_len = CW'(8);
    exp_err = 1'b1;
`else
    exp_len = '0;
    exp_err = 1'b0;
`endif
    pulse_clr();
    checks++;
    if (err_line_len !== 1'b0) begin failures++; $display("FAIL linelen_idle got=%b exp=0", err_line_len); end
    lens = '{8, 8, 7, 0, 0, 0, 0, 0};
    drive_frame(3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (line_len !== exp_len) begin failures++; $display("FAIL linelen_ref got=%0d exp=%0d", line_len, exp_len); end
    checks++;
    if (err_line_len !== exp_err) begin failures++; $display("FAIL linelen_err got=%b exp=%b", err_line_len, exp_err); end
    pulse_clr();
    lens = '{8, 8, 5, 0, 0, 0, 0, 0};
    drive_frame(3, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    checks++;
    if (err_line_len !== 1'b0) begin failures++; $display("FAIL linelen_trunc got=%b exp=0", err_line_len); end
    checks++;
    if (line_len !== exp_len) begin failures++; $display("FAIL linelen_ref2 got=%0d exp=%0d", line_len, exp_len); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL linelen_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  task automatic test_random;
    int nl;
    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(1, 5);
      for (int l = 0; l < 8; l++) lens[l] = $urandom_range(1, 10);
      drive_frame(nl, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b0, 1'b0, 1'b0);
    end
    lines_max = '0;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_pix[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (eof_obs != eof_exp) begin failures++; $display("FAIL rand_eof got=%0d pulses exp=%0d", eof_obs.size(), eof_exp.size()); end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL stray_markers got=%0d exp=0", stray); end
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL dout_hold got=%0d exp=0", hold_err); end
    exp_q.delete(); obs_q.delete(); eof_exp.delete(); eof_obs.delete();
  endtask

  initial begin
    rst       = 1'b1;
    hact      = 1'b0;
    vact      = 1'b0;
    pxd       = '0;
    frame_en  = 1'b1;
    lines_max = '0;
    err_clr   = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid_frame();
    test_line_limit();
    test_hact_err();
    test_frame_en();
    test_truncate_empty();
    test_line_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
